// File: rtl/sfp_pkg.sv
// Shared constants for the SFP sample-buffer RAMs: read-during-write policy codes,
// error-counter width and the default buffer geometry.
package sfp_pkg;

   localparam int RDW_OLD    = 0;
   localparam int RDW_NEW    = 1;
   localparam int OOR_CNT_W  = 16;

   localparam int SFP_DATA_W = 16;
   localparam int SFP_ADDR_W = 15;
   localparam int SFP_DEPTH  = 25001;

   typedef logic [OOR_CNT_W-1:0] oor_cnt_t;

   // Adds an increment of 0..2 and sticks at all-ones instead of wrapping.
   function automatic oor_cnt_t oor_sat_add(input oor_cnt_t cnt, input logic [1:0] inc);
      logic [OOR_CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(OOR_CNT_W-1){1'b0}}, inc};
      return sum[OOR_CNT_W] ? '1 : sum[OOR_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Bare DEPTH x DATA_W storage: one synchronous write, one registered read, no reset,
// so the array maps straight onto block RAM. A same-address read returns the old word.
module sdp_ram_core #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 15,
   parameter int DEPTH  = 25001
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata_q
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple-dual-port sample buffer wrapper: address range checks, optional write-to-read
// bypass, fixed-latency valid pipeline (1 or 2 cycles) and a saturating error counter.
module sdp_ram_pipe
   import sfp_pkg::*;
#(
   parameter int DATA_W   = SFP_DATA_W,
   parameter int ADDR_W   = SFP_ADDR_W,
   parameter int DEPTH    = SFP_DEPTH,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = RDW_OLD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    data,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic                 wr_ena,
   input  logic [ADDR_W-1:0]    rd_addr,
   input  logic                 rd_ena,
   output logic [DATA_W-1:0]    q,
   output logic                 dval,
   output logic                 rd_oor,
   output logic                 wr_oor,
   input  logic                 clr_cnt,
   output logic [OOR_CNT_W-1:0] oor_cnt
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam bit              BYPASS  = (RDW_MODE == RDW_NEW);

   generate
      if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
         $error("sdp_ram_pipe: RD_LAT must be 1 or 2");
      end
      if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
         $error("sdp_ram_pipe: DEPTH must lie in 1 .. 2**ADDR_W");
      end
      if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
         $error("sdp_ram_pipe: RDW_MODE must be 0 or 1");
      end
   endgenerate

   logic              wr_in_range, rd_in_range, wr_acc, rd_acc, rd_hit;
   logic [DATA_W-1:0] ram_q, s1_data;

   logic              v1_d, v1_q, oor1_d, oor1_q, zero1_d, zero1_q, byp1_d, byp1_q;
   logic [DATA_W-1:0] byp_data1_d, byp_data1_q;
   logic              v2_d, v2_q, oor2_d, oor2_q;
   logic [DATA_W-1:0] q2_d, q2_q;
   logic              wr_oor_d, wr_oor_q, rd_oor_ev;
   oor_cnt_t          cnt_d, cnt_q;

   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
      rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
      wr_acc      = wr_ena && wr_in_range && !rst;
      rd_acc      = rd_ena && !rst;
      rd_hit      = BYPASS && wr_acc && rd_ena && rd_in_range && (rd_addr == wr_addr);
   end

   sdp_ram_core #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk     (clk),
      .we      (wr_acc),
      .waddr   (wr_addr[IDX_W-1:0]),
      .wdata   (data),
      .re      (rd_acc && rd_in_range),
      .raddr   (rd_addr[IDX_W-1:0]),
      .rdata_q (ram_q)
   );

   // Stage-1 select flops only move on an accepted read, so q holds between reads
   // even though the core output register is not reset.
   always_comb begin
      v1_d        = rd_acc;
      oor1_d      = rd_acc && !rd_in_range;
      zero1_d     = zero1_q;
      byp1_d      = byp1_q;
      byp_data1_d = byp_data1_q;
      if (rd_acc) begin
         zero1_d     = !rd_in_range;
         byp1_d      = rd_hit;
         byp_data1_d = data;
      end
      s1_data = zero1_q ? '0 : (byp1_q ? byp_data1_q : ram_q);

      v2_d   = v1_q;
      oor2_d = oor1_q;
      q2_d   = v1_q ? s1_data : q2_q;

      // A write error counts with wr_oor, a read error with the rd_oor it raises.
      wr_oor_d  = wr_ena && !wr_in_range;
      rd_oor_ev = (RD_LAT == 1) ? oor1_d : oor2_d;
      cnt_d     = clr_cnt ? '0 : oor_sat_add(cnt_q, {1'b0, wr_oor_d} + {1'b0, rd_oor_ev});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         oor1_q      <= 1'b0;
         zero1_q     <= 1'b1;
         byp1_q      <= 1'b0;
         byp_data1_q <= '0;
         v2_q        <= 1'b0;
         oor2_q      <= 1'b0;
         q2_q        <= '0;
         wr_oor_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         v1_q        <= v1_d;
         oor1_q      <= oor1_d;
         zero1_q     <= zero1_d;
         byp1_q      <= byp1_d;
         byp_data1_q <= byp_data1_d;
         v2_q        <= v2_d;
         oor2_q      <= oor2_d;
         q2_q        <= q2_d;
         wr_oor_q    <= wr_oor_d;
         cnt_q       <= cnt_d;
      end
   end

   assign q       = (RD_LAT == 1) ? s1_data : q2_q;
   assign dval    = (RD_LAT == 1) ? v1_q    : v2_q;
   assign rd_oor  = (RD_LAT == 1) ? oor1_q  : oor2_q;
   assign wr_oor  = wr_oor_q;
   assign oor_cnt = cnt_q;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Bench for sdp_ram_pipe: two instances share all inputs, one RD_LAT=1 / old-data,
// one RD_LAT=2 / new-data bypass, so both latencies and both collision policies are seen.
module tb_sdp_ram_pipe;
   import sfp_pkg::*;

   localparam int DW = 16;
   localparam int AW = 15;
   localparam int NV = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data = '0;
   logic [AW-1:0] wr_addr = '0;
   logic          wr_ena = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_ena = 1'b0;
   logic          clr_cnt = 1'b0;

   logic [DW-1:0] q1, q2;
   logic          dval1, dval2, rd_oor1, rd_oor2, wr_oor1, wr_oor2;
   logic [15:0]   cnt1, cnt2;

   always #5 clk = ~clk;

   sdp_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(25001), .RD_LAT(1), .RDW_MODE(RDW_OLD)) u_lat1 (
      .clk(clk), .rst(rst), .data(data), .wr_addr(wr_addr), .wr_ena(wr_ena),
      .rd_addr(rd_addr), .rd_ena(rd_ena), .q(q1), .dval(dval1), .rd_oor(rd_oor1),
      .wr_oor(wr_oor1), .clr_cnt(clr_cnt), .oor_cnt(cnt1)
   );

   sdp_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(25001), .RD_LAT(2), .RDW_MODE(RDW_NEW)) u_lat2 (
      .clk(clk), .rst(rst), .data(data), .wr_addr(wr_addr), .wr_ena(wr_ena),
      .rd_addr(rd_addr), .rd_ena(rd_ena), .q(q2), .dval(dval2), .rd_oor(rd_oor2),
      .wr_oor(wr_oor2), .clr_cnt(clr_cnt), .oor_cnt(cnt2)
   );

   // ---------------- scoreboard and helpers ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] hold1 = '0;
   logic [DW-1:0] hold2 = '0;
   int            exp_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance past one rising edge; outputs are sampled and inputs changed 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_ena  = 1'b0;
      rd_ena  = 1'b0;
      clr_cnt = 1'b0;
   endtask

   task automatic read_both(input string name, input int addr, input logic [DW-1:0] exp);
      rd_ena  = 1'b1;
      rd_addr = addr[AW-1:0];
      step();
      idle();
      check({name, " lat1 dval"}, dval1, 1);
      check({name, " lat1 q"}, q1, exp);
      check({name, " lat2 early dval"}, dval2, 0);
      step();
      check({name, " lat2 dval"}, dval2, 1);
      check({name, " lat2 q"}, q2, exp);
      hold1 = exp;
      hold2 = exp;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          rd;
      logic [AW-1:0] ra;
      logic [DW-1:0] exp_old;
      logic [DW-1:0] exp_new;
      logic          exp_rd_oor;
      logic          exp_wr_oor;
   } vec_t;

   vec_t vecs[NV];
   vec_t v;

   function automatic vec_t mk(input int wr, input int wa, input int wd, input int rd,
                               input int ra, input int eo, input int en, input int ro, input int wo);
      vec_t r;
      r.wr = wr[0];  r.wa = wa[AW-1:0]; r.wd = wd[DW-1:0];
      r.rd = rd[0];  r.ra = ra[AW-1:0];
      r.exp_old = eo[DW-1:0]; r.exp_new = en[DW-1:0];
      r.exp_rd_oor = ro[0]; r.exp_wr_oor = wo[0];
      return r;
   endfunction

   initial begin
      //          wr  waddr  wdata    rd  raddr  old      new      rdoor wroor
      vecs[0]  = mk(1, 100,   'hA5A5,  0, 0,     0,       0,       0, 0);
      vecs[1]  = mk(0, 0,     0,       1, 100,   'hA5A5,  'hA5A5,  0, 0);
      vecs[2]  = mk(1, 5,     'h1111,  0, 0,     0,       0,       0, 0);
      vecs[3]  = mk(1, 5,     'h2222,  1, 5,     'h1111,  'h2222,  0, 0);
      vecs[4]  = mk(0, 0,     0,       1, 5,     'h2222,  'h2222,  0, 0);
      vecs[5]  = mk(1, 25001, 'hDEAD,  0, 0,     0,       0,       0, 1);
      vecs[6]  = mk(0, 0,     0,       1, 30000, 0,       0,       1, 0);
      vecs[7]  = mk(1, 25000, 'hBEEF,  0, 0,     0,       0,       0, 0);
      vecs[8]  = mk(0, 0,     0,       1, 25000, 'hBEEF,  'hBEEF,  0, 0);
      vecs[9]  = mk(1, 6,     'h0666,  0, 0,     0,       0,       0, 0);
      vecs[10] = mk(1, 7,     'h0777,  1, 6,     'h0666,  'h0666,  0, 0);
      vecs[11] = mk(0, 0,     0,       1, 7,     'h0777,  'h0777,  0, 0);
      vecs[12] = mk(1, 32767, 'h1234,  1, 32767, 0,       0,       1, 1);
      vecs[13] = mk(1, 0,     'hFFFF,  1, 100,   'hA5A5,  'hA5A5,  0, 0);
      vecs[14] = mk(0, 0,     0,       1, 0,     'hFFFF,  'hFFFF,  0, 0);
      vecs[15] = mk(1, 24999, 'h0042,  1, 25000, 'hBEEF,  'hBEEF,  0, 0);

      // ---------------- reset state ----------------
      rst = 1'b1;
      repeat (3) step();
      check("rst lat1 q", q1, 0);       check("rst lat2 q", q2, 0);
      check("rst lat1 dval", dval1, 0); check("rst lat2 dval", dval2, 0);
      check("rst lat1 rd_oor", rd_oor1, 0); check("rst lat2 rd_oor", rd_oor2, 0);
      check("rst wr_oor", {wr_oor1, wr_oor2}, 0);
      check("rst lat1 cnt", cnt1, 0);   check("rst lat2 cnt", cnt2, 0);
      rst = 1'b0;
      step();

      // ---------------- table-driven single transactions ----------------
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         wr_ena = v.wr; wr_addr = v.wa; data = v.wd;
         rd_ena = v.rd; rd_addr = v.ra;
         step();
         idle();
         if (v.rd) hold1 = v.exp_old;
         exp_cnt = exp_cnt + int'(v.exp_wr_oor) + int'(v.exp_rd_oor);
         check($sformatf("v%0d lat1 dval", i), dval1, v.rd);
         check($sformatf("v%0d lat1 q", i), q1, hold1);
         check($sformatf("v%0d lat1 rd_oor", i), rd_oor1, v.exp_rd_oor);
         check($sformatf("v%0d lat1 wr_oor", i), wr_oor1, v.exp_wr_oor);
         check($sformatf("v%0d lat2 wr_oor", i), wr_oor2, v.exp_wr_oor);
         check($sformatf("v%0d lat1 cnt", i), cnt1, exp_cnt);
         check($sformatf("v%0d lat2 early dval", i), dval2, 0);
         check($sformatf("v%0d lat2 q hold", i), q2, hold2);
         step();
         if (v.rd) hold2 = v.exp_new;
         check($sformatf("v%0d lat1 dval off", i), dval1, 0);
         check($sformatf("v%0d lat1 q hold", i), q1, hold1);
         check($sformatf("v%0d wr_oor off", i), {wr_oor1, wr_oor2}, 0);
         check($sformatf("v%0d lat2 dval", i), dval2, v.rd);
         check($sformatf("v%0d lat2 q", i), q2, hold2);
         check($sformatf("v%0d lat2 rd_oor", i), rd_oor2, v.exp_rd_oor);
         check($sformatf("v%0d lat2 cnt", i), cnt2, exp_cnt);
      end

      // ---------------- back-to-back reads ----------------
      for (int a = 0; a < 8; a++) begin
         wr_ena = 1'b1; wr_addr = a[AW-1:0]; data = DW'(16'h1000 + a);
         step();
      end
      idle();
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            rd_ena = 1'b1; rd_addr = k[AW-1:0];
            exp_q.push_back(DW'(16'h1000 + k));
         end else begin
            rd_ena = 1'b0;
         end
         step();
         check($sformatf("b2b%0d lat1 dval", k), dval1, (k < 8));
         check($sformatf("b2b%0d lat1 q", k), q1, 16'h1000 + ((k < 8) ? k : 7));
         check($sformatf("b2b%0d lat2 dval", k), dval2, (k >= 1 && k <= 8));
         if (k >= 1 && k <= 8 && exp_q.size() > 0)
            check($sformatf("b2b%0d lat2 q", k), q2, exp_q.pop_front());
      end
      idle();
      check("b2b leftover", exp_q.size(), 0);

      // ---------------- write then read on the next cycle ----------------
      wr_ena = 1'b1; wr_addr = 9; data = 16'h0999;
      step();
      wr_ena = 1'b0;
      read_both("wr_then_rd", 9, 16'h0999);

      // ---------------- counter saturation and clear ----------------
      for (int i = 0; i < 35000; i++) begin
         wr_ena = 1'b1; wr_addr = 15'd30000;
         rd_ena = 1'b1; rd_addr = 15'd30001;
         step();
      end
      idle();
      step();
      step();
      check("sat lat1 cnt", cnt1, 16'hFFFF);
      check("sat lat2 cnt", cnt2, 16'hFFFF);
      check("sat lat1 q zero", q1, 0);
      check("sat lat2 q zero", q2, 0);
      rd_ena = 1'b1; rd_addr = 15'd30001; clr_cnt = 1'b1;
      step();
      idle();
      check("clr lat1 rd_oor", rd_oor1, 1);
      check("clr lat1 cnt", cnt1, 0);
      check("clr lat2 cnt", cnt2, 0);
      step();
      check("clr lat2 rd_oor", rd_oor2, 1);
      check("post-clr lat1 cnt", cnt1, 0);
      // The RD_LAT=2 read reports its error one cycle after the clear.
      check("post-clr lat2 cnt", cnt2, 1);
      hold1 = '0;
      hold2 = '0;

      // ---------------- reset mid-operation ----------------
      for (int k = 0; k < 3; k++) begin
         rd_ena = 1'b1; rd_addr = k[AW-1:0];
         step();
         check($sformatf("pre-rst%0d lat1 q", k), q1, 16'h1000 + k);
         if (k > 0) check($sformatf("pre-rst%0d lat2 q", k), q2, 16'h1000 + k - 1);
      end
      // Requests and a write presented during reset must be ignored.
      rst = 1'b1;
      rd_ena = 1'b1; rd_addr = 3;
      wr_ena = 1'b1; wr_addr = 100; data = 16'h7777;
      step();
      rst = 1'b0;
      idle();
      check("in-rst lat1 dval", dval1, 0); check("in-rst lat2 dval", dval2, 0);
      check("in-rst lat1 q", q1, 0);       check("in-rst lat2 q", q2, 0);
      check("in-rst cnt", {cnt1, cnt2}, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post-rst%0d dval", k), {dval1, dval2}, 0);
         check($sformatf("post-rst%0d q", k), {q1, q2}, 0);
      end
      read_both("post-rst addr100", 100, 16'hA5A5);
      read_both("post-rst addr2", 2, 16'h1002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
